// File: rtl/mcu_dispatch.sv
// MCU byte-stream dispatcher: routes framed bytes to one of four targets or a local status responder.
// Target strobes and data_out are registered one cycle after the MCU strobe; no backpressure, strobes >= 2 cycles apart.
module mcu_dispatch #(
    parameter logic [23:0] TIMEOUT = 24'd2_700_000,
    parameter logic [7:0]  CORE_ID = 8'h02
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in_strobe,
    input  logic       data_in_start,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       int_out_n,
    output logic [3:0] tgt_strobe,
    output logic       tgt_start,
    output logic [7:0] tgt_data,
    input  logic [7:0] tgt_dout0,
    input  logic [7:0] tgt_dout1,
    input  logic [7:0] tgt_dout2,
    input  logic [7:0] tgt_dout3,
    input  logic [3:0] tgt_int_n,
    output logic [3:0] irq_mask
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_FORWARD,
        S_LOCAL,
        S_DISCARD
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  id;
    logic [7:0]  id_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic [23:0] to_cnt;
    logic [3:0]  pending;
    logic        start_stb;
    logic        byte_stb;
    logic        timed_out;
    logic        fwd_fire;
    logic        mask_wr;
    logic [7:0]  fwd_dout;
    logic [7:0]  local_dout;
    logic [7:0]  dout_nxt;

    assign start_stb = data_in_strobe & data_in_start;
    assign byte_stb  = data_in_strobe & ~data_in_start;
    assign pending   = ~tgt_int_n & irq_mask;
    assign timed_out = (state != S_IDLE) && !data_in_strobe && (to_cnt >= TIMEOUT - 24'd1);

    always_comb begin
        state_nxt = state;
        id_nxt    = id;
        cnt_nxt   = cnt;
        fwd_fire  = 1'b0;
        mask_wr   = 1'b0;
        if (start_stb) begin
            // A start always reopens a frame, silently dropping whatever was in flight.
            state_nxt = S_SELECT;
            id_nxt    = data_in;
            cnt_nxt   = 4'd0;
        end else if (byte_stb && state != S_IDLE) begin
            cnt_nxt = (cnt == 4'hF) ? cnt : cnt + 4'd1;
            if (state == S_SELECT) begin
                if (id <= 8'd3)
                    state_nxt = S_FORWARD;
                else if (id == 8'hFF)
                    state_nxt = S_LOCAL;
                else
                    state_nxt = S_DISCARD;
            end
            fwd_fire = (state_nxt == S_FORWARD);
            mask_wr  = (state_nxt == S_LOCAL) && (cnt_nxt == 4'd2);
        end else if (timed_out) begin
            state_nxt = S_IDLE;
            cnt_nxt   = 4'd0;
        end
    end

    always_comb begin
        fwd_dout = tgt_dout0;
        case (id_nxt[1:0])
            2'd0: fwd_dout = tgt_dout0;
            2'd1: fwd_dout = tgt_dout1;
            2'd2: fwd_dout = tgt_dout2;
            2'd3: fwd_dout = tgt_dout3;
            default: fwd_dout = tgt_dout0;
        endcase
    end

    // The byte-3 status is live: it tracks pending while the frame sits on that byte.
    always_comb begin
        local_dout = 8'h00;
        case (cnt_nxt)
            4'd1: local_dout = 8'hD5;
            4'd2: local_dout = CORE_ID;
            4'd3: local_dout = {4'h0, pending};
            default: local_dout = 8'h00;
        endcase
    end

    always_comb begin
        dout_nxt = 8'hFF;
        case (state_nxt)
            S_FORWARD: dout_nxt = fwd_dout;
            S_LOCAL:   dout_nxt = local_dout;
            default:   dout_nxt = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            id         <= 8'h00;
            cnt        <= 4'd0;
            to_cnt     <= 24'd0;
            tgt_strobe <= 4'b0000;
            tgt_start  <= 1'b0;
            tgt_data   <= 8'h00;
            data_out   <= 8'hFF;
            irq_mask   <= 4'hF;
            int_out_n  <= 1'b1;
        end else begin
            state <= state_nxt;
            id    <= id_nxt;
            cnt   <= cnt_nxt;
            if (data_in_strobe || state_nxt == S_IDLE)
                to_cnt <= 24'd0;
            else
                to_cnt <= to_cnt + 24'd1;
            tgt_strobe <= fwd_fire ? (4'b0001 << id_nxt[1:0]) : 4'b0000;
            if (fwd_fire) begin
                tgt_data  <= data_in;
                tgt_start <= (cnt_nxt == 4'd1);
            end
            if (mask_wr)
                irq_mask <= data_in[3:0];
            data_out  <= dout_nxt;
            int_out_n <= ~|pending;
        end
    end

endmodule
